// File: rtl/urd_tx_pkg.sv
// Shared types and constants for the TX frame encoder.
// The optional padding feature is enabled by defining URD_TX_FENC_PAD_EN.
package urd_tx_pkg;

  localparam int unsigned TX_LEN_W       = 14;
  localparam int unsigned TX_DATA_W      = 64;
  localparam int unsigned TX_MIN_FRAME   = 60;
  localparam int unsigned HDR_CONCAT_BIT = TX_LEN_W;
  localparam int unsigned HDR_RSVD_W     = TX_DATA_W - TX_LEN_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PAD     = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } state_e;

  // Header word layout: length in the low bits, concat flag just above it.
  typedef struct packed {
    logic [HDR_RSVD_W-1:0] rsvd;
    logic                  concat;
    logic [TX_LEN_W-1:0]   len;
  } hdr_t;

  typedef struct packed {
    logic       valid;
    logic       err;
    logic [7:0] id;
  } event_t;

endpackage

// File: rtl/urd_tx_fenc_word_cnt.sv
// Loadable down-counter with a registered last-word flag.
// Counts payload words of a job and, when padding is enabled, pad words.
module urd_tx_fenc_word_cnt
  import urd_tx_pkg::*;
#(
  parameter int unsigned CNT_W = TX_LEN_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             last_q;

  // Load wins over decrement; last flag tracks cnt==1 without a comparator on the output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else if (load_i) begin
      cnt_q  <= load_val_i;
      last_q <= (load_val_i == CNT_W'(1));
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q  <= cnt_q - CNT_W'(1);
      last_q <= (cnt_q == CNT_W'(2));
    end
  end

  assign last_o = last_q;

endmodule

// File: rtl/urd_tx_fenc_controller_fsm.sv
// TX frame encoder controller: pops jobs, writes header + payload words into
// the TX FIFO, chains concatenated jobs into one frame, turns error jobs into
// error events. Optional minimum-frame padding under URD_TX_FENC_PAD_EN.
// FIFO-side handshakes are decoded from the registered state and the current
// cycle's space/dav inputs so that a write only ever happens in a cycle where
// the FIFO can take it.
module urd_tx_fenc_controller_fsm
  import urd_tx_pkg::*;
#(
  parameter int unsigned LEN_W  = TX_LEN_W,
  parameter int unsigned DATA_W = TX_DATA_W
`ifdef URD_TX_FENC_PAD_EN
  , parameter int unsigned MIN_FRAME = TX_MIN_FRAME
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  input  logic [LEN_W-1:0]  job_len,
  input  logic              job_concat,
  input  logic              job_err,
  input  logic [7:0]        job_err_id,
  output logic              job_pop,
  input  logic              pl_dav,
  input  logic [DATA_W-1:0] pl_data,
  output logic              pl_rd,
  input  logic              txf_space,
  output logic              txf_wr,
  output logic [DATA_W-1:0] txf_data,
  output logic              txf_sof,
  output logic              txf_eof,
  output logic              txf_abort,
  output logic              ev_valid,
  output logic              ev_err,
  output logic [7:0]        ev_id,
  output logic              busy
);

  localparam int unsigned CNT_W = LEN_W + 1;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             concat_q, concat_d;
  logic [7:0]       err_id_q, err_id_d;
  logic             in_frame_q, in_frame_d;

  logic             cnt_load, cnt_dec, cnt_last;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] job_words;
  logic             pad_needed;
  event_t           ev;

  assign job_words = CNT_W'((CNT_W'(len_q) + CNT_W'(7)) >> 3);

`ifdef URD_TX_FENC_PAD_EN
  localparam int unsigned PAD_WORDS = (MIN_FRAME + 7) / 8;

  logic [CNT_W-1:0] frame_bytes_q, frame_bytes_d;
  logic [CNT_W-1:0] frame_words_q, frame_words_d;
  logic [CNT_W:0]   bytes_sum;
  logic [CNT_W-1:0] pad_cnt;
  logic             good_pop;

  assign good_pop  = (state_q == ST_IDLE) && job_valid && !job_err;
  assign bytes_sum = {1'b0, frame_bytes_q} + (CNT_W + 1)'(job_len);

  // Frame byte total: restarts on the first job of a frame, saturates.
  always_comb begin
    frame_bytes_d = frame_bytes_q;
    if (good_pop) begin
      if (!in_frame_q) begin
        frame_bytes_d = CNT_W'(job_len);
      end else if (bytes_sum[CNT_W]) begin
        frame_bytes_d = '1;
      end else begin
        frame_bytes_d = bytes_sum[CNT_W-1:0];
      end
    end
  end

  // Payload words already in the frame, saturating at the pad target.
  always_comb begin
    frame_words_d = frame_words_q;
    if (good_pop && !in_frame_q) begin
      frame_words_d = '0;
    end else if ((state_q == ST_PAYLOAD) && pl_dav && txf_space &&
                 (frame_words_q < CNT_W'(PAD_WORDS))) begin
      frame_words_d = frame_words_q + CNT_W'(1);
    end
  end

  // Pad up to the target word count; at least one pad word so the eof is carried.
  assign pad_needed = !concat_q && (frame_bytes_q < CNT_W'(MIN_FRAME));
  assign pad_cnt    = (frame_words_d < CNT_W'(PAD_WORDS)) ?
                      (CNT_W'(PAD_WORDS) - frame_words_d) : CNT_W'(1);

  // Frame accumulators.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_bytes_q <= '0;
      frame_words_q <= '0;
    end else begin
      frame_bytes_q <= frame_bytes_d;
      frame_words_q <= frame_words_d;
    end
  end
`else
  assign pad_needed = 1'b0;
`endif

  // State and job latches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      concat_q   <= 1'b0;
      err_id_q   <= '0;
      in_frame_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      concat_q   <= concat_d;
      err_id_q   <= err_id_d;
      in_frame_q <= in_frame_d;
    end
  end

  // Next state, FIFO handshakes and event generation.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    concat_d   = concat_q;
    err_id_d   = err_id_q;
    in_frame_d = in_frame_q;
    job_pop    = 1'b0;
    pl_rd      = 1'b0;
    txf_wr     = 1'b0;
    txf_data   = '0;
    txf_sof    = 1'b0;
    txf_eof    = 1'b0;
    txf_abort  = 1'b0;
    ev         = '0;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (job_valid && rst_n) begin
          job_pop  = 1'b1;
          len_d    = job_len;
          concat_d = job_concat;
          err_id_d = job_err_id;
          state_d  = job_err ? ST_ERR : ST_HDR;
        end
      end

      ST_HDR: begin
        if (txf_space) begin
          txf_wr   = 1'b1;
          txf_data = DATA_W'({concat_q, len_q});
          txf_sof  = !in_frame_q;
          cnt_load = 1'b1;
          if (len_q == '0) begin
            txf_eof = !concat_q && !pad_needed;
            state_d = ST_DONE;
`ifdef URD_TX_FENC_PAD_EN
            if (pad_needed) begin
              cnt_val = pad_cnt;
              state_d = ST_PAD;
            end
`endif
          end else begin
            cnt_val = job_words;
            state_d = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (pl_dav && txf_space) begin
          pl_rd    = 1'b1;
          txf_wr   = 1'b1;
          txf_data = pl_data;
          cnt_dec  = 1'b1;
          if (cnt_last) begin
            txf_eof = !concat_q && !pad_needed;
            state_d = ST_DONE;
`ifdef URD_TX_FENC_PAD_EN
            if (pad_needed) begin
              cnt_load = 1'b1;
              cnt_val  = pad_cnt;
              state_d  = ST_PAD;
            end
`endif
          end
        end
      end

`ifdef URD_TX_FENC_PAD_EN
      ST_PAD: begin
        if (txf_space) begin
          txf_wr  = 1'b1;
          cnt_dec = 1'b1;
          if (cnt_last) begin
            txf_eof = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
`endif

      ST_DONE: begin
        ev.valid   = 1'b1;
        in_frame_d = concat_q;
        state_d    = ST_IDLE;
      end

      ST_ERR: begin
        ev.valid   = 1'b1;
        ev.err     = 1'b1;
        ev.id      = err_id_q;
        txf_abort  = in_frame_q;
        in_frame_d = 1'b0;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  urd_tx_fenc_word_cnt #(
    .CNT_W(CNT_W)
  ) u_word_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .dec_i     (cnt_dec),
    .last_o    (cnt_last)
  );

  assign ev_valid = ev.valid;
  assign ev_err   = ev.err;
  assign ev_id    = ev.id;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_urd_tx_fenc_controller_fsm.sv
// Self-checking bench for urd_tx_fenc_controller_fsm: job/payload sources,
// a frame-level reference model feeding write/event scoreboards, a vector
// table, timing sequences and a randomized run.
module tb_urd_tx_fenc_controller_fsm;

  localparam int unsigned LEN_W     = 14;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned MIN_FRAME = 60;
  localparam int unsigned PAD_WORDS = 8;
`ifdef URD_TX_FENC_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              job_valid = 1'b0;
  logic [LEN_W-1:0]  job_len = '0;
  logic              job_concat = 1'b0;
  logic              job_err = 1'b0;
  logic [7:0]        job_err_id = '0;
  logic              job_pop;
  logic              pl_dav = 1'b0;
  logic [DATA_W-1:0] pl_data = '0;
  logic              pl_rd;
  logic              txf_space = 1'b0;
  logic              txf_wr;
  logic [DATA_W-1:0] txf_data;
  logic              txf_sof, txf_eof, txf_abort;
  logic              ev_valid, ev_err;
  logic [7:0]        ev_id;
  logic              busy;

  urd_tx_fenc_controller_fsm dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_len(job_len), .job_concat(job_concat),
    .job_err(job_err), .job_err_id(job_err_id), .job_pop(job_pop),
    .pl_dav(pl_dav), .pl_data(pl_data), .pl_rd(pl_rd),
    .txf_space(txf_space), .txf_wr(txf_wr), .txf_data(txf_data),
    .txf_sof(txf_sof), .txf_eof(txf_eof), .txf_abort(txf_abort),
    .ev_valid(ev_valid), .ev_err(ev_err), .ev_id(ev_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [LEN_W-1:0] len; bit concat; bit err; logic [7:0] id; } job_t;
  typedef struct { logic [DATA_W-1:0] data; bit sof; bit eof; } wr_t;
  typedef struct { bit err; logic [7:0] id; bit abort; } ev_t;
  typedef struct {
    logic [LEN_W-1:0] len; bit concat; bit err; logic [7:0] id;
    int nwr_nopad; int nwr_pad; bit ev_err; logic [7:0] ev_id; bit abort;
  } vec_t;

  job_t              job_q[$];
  logic [DATA_W-1:0] pl_q[$];
  wr_t               exp_wr[$];
  ev_t               exp_ev[$];
  int                pop_cyc[$], wr_cyc[$], ev_cyc[$];

  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  n_wr_seen, n_ev_seen;
  ev_t last_ev;
  int  space_mode = 0;
  int  dav_mode = 0;
  int  force_low = 0;

  bit  m_in_frame = 1'b0;
  int  m_bytes = 0;
  int  m_words = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Reference model: expand a job into the FIFO words and event it must produce.
  task automatic push_job(input job_t j);
    int nw, npad;
    bit padn;
    wr_t w;
    job_q.push_back(j);
    if (j.err) begin
      exp_ev.push_back('{1'b1, j.id, m_in_frame});
      m_in_frame = 1'b0;
      return;
    end
    if (!m_in_frame) begin
      m_bytes = 0;
      m_words = 0;
    end
    m_bytes += int'(j.len);
    nw = (int'(j.len) + 7) / 8;
    m_words += nw;
    padn = PAD && !j.concat && (m_bytes < MIN_FRAME);
    npad = !padn ? 0 : ((m_words < PAD_WORDS) ? (PAD_WORDS - m_words) : 1);
    w.data = DATA_W'(j.len) | (DATA_W'(j.concat) << LEN_W);
    w.sof  = !m_in_frame;
    w.eof  = (nw == 0) && !j.concat && !padn;
    exp_wr.push_back(w);
    for (int i = 0; i < nw; i++) begin
      w.data = {$urandom, $urandom};
      w.sof  = 1'b0;
      w.eof  = (i == nw - 1) && !j.concat && !padn;
      pl_q.push_back(w.data);
      exp_wr.push_back(w);
    end
    for (int i = 0; i < npad; i++) begin
      w.data = '0;
      w.sof  = 1'b0;
      w.eof  = (i == npad - 1);
      exp_wr.push_back(w);
    end
    exp_ev.push_back('{1'b0, 8'h00, 1'b0});
    m_in_frame = j.concat;
  endtask

  task automatic monitor();
    ev_t e;
    wr_t w;
    if (!rst_n) return;
    check("protocol",
          64'((txf_wr && !txf_space) || (job_pop && txf_wr) || (job_pop && !job_valid) ||
              (pl_rd && !(pl_dav && txf_space && txf_wr)) ||
              ((txf_sof || txf_eof) && !txf_wr) ||
              (txf_abort && !(ev_valid && ev_err)) ||
              (ev_valid && !ev_err && ev_id != 8'h00)), 64'd0);
    if (job_pop) begin
      pop_cyc.push_back(cyc);
      if (job_q.size() != 0) void'(job_q.pop_front());
    end
    if (pl_rd && pl_q.size() != 0) void'(pl_q.pop_front());
    if (txf_wr) begin
      wr_cyc.push_back(cyc);
      n_wr_seen++;
      if (exp_wr.size() == 0) fail_now("wr_unexpected");
      else begin
        w = exp_wr.pop_front();
        check("wr_data", txf_data, w.data);
        check("wr_sof", 64'(txf_sof), 64'(w.sof));
        check("wr_eof", 64'(txf_eof), 64'(w.eof));
      end
    end
    if (ev_valid) begin
      ev_cyc.push_back(cyc);
      n_ev_seen++;
      last_ev = '{ev_err, ev_id, txf_abort};
      if (exp_ev.size() == 0) fail_now("ev_unexpected");
      else begin
        e = exp_ev.pop_front();
        check("ev_err", 64'(ev_err), 64'(e.err));
        check("ev_id", 64'(ev_id), 64'(e.id));
        check("ev_abort", 64'(txf_abort), 64'(e.abort));
      end
    end
  endtask

  // One clock: drive inputs just after the edge, sample outputs on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    job_valid = (job_q.size() != 0);
    if (job_valid) begin
      job_len = job_q[0].len; job_concat = job_q[0].concat;
      job_err = job_q[0].err; job_err_id = job_q[0].id;
    end else begin
      job_len = '0; job_concat = 1'b0; job_err = 1'b0; job_err_id = '0;
    end
    pl_dav = (pl_q.size() != 0) &&
             ((dav_mode == 0) || (dav_mode == 1 && ($urandom % 3) != 0) ||
              (dav_mode == 2 && (cyc % 2) == 0));
    pl_data = (pl_q.size() != 0) ? pl_q[0] : '0;
    if (force_low > 0) begin
      txf_space = 1'b0;
      force_low--;
    end else begin
      txf_space = (space_mode == 0) ? 1'b1 : (($urandom % 4) != 0);
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      done = (job_q.size() == 0) && (exp_wr.size() == 0) && (exp_ev.size() == 0) && !busy;
    end
    if (!done) fail_now({name, "_drain_timeout"});
    check({name, "_pl_left"}, 64'(pl_q.size()), 64'd0);
  endtask

  task automatic clear_trace();
    pop_cyc.delete(); wr_cyc.delete(); ev_cyc.delete();
    n_wr_seen = 0;
    n_ev_seen = 0;
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {job_pop, pl_rd, txf_wr, txf_sof, txf_eof, txf_abort, ev_valid, ev_err, busy}, 64'd0);
    check({name, "_data"}, txf_data | DATA_W'(ev_id), 64'd0);
  endtask

  task automatic step_until_writes(input int n);
    for (int i = 0; i < 200 && wr_cyc.size() < n; i++) step();
    if (wr_cyc.size() < n) fail_now("wait_writes_timeout");
  endtask

  vec_t vecs[10];

  initial begin
    job_t j;
    int   nlast;
    vecs[0] = '{14'd16, 1'b0, 1'b0, 8'h00, 3, 9,  1'b0, 8'h00, 1'b0};
    vecs[1] = '{14'd8,  1'b1, 1'b0, 8'h00, 2, 2,  1'b0, 8'h00, 1'b0};
    vecs[2] = '{14'd13, 1'b0, 1'b0, 8'h00, 3, 8,  1'b0, 8'h00, 1'b0};
    vecs[3] = '{14'd0,  1'b0, 1'b0, 8'h00, 1, 9,  1'b0, 8'h00, 1'b0};
    vecs[4] = '{14'd64, 1'b1, 1'b0, 8'h00, 9, 9,  1'b0, 8'h00, 1'b0};
    vecs[5] = '{14'd0,  1'b0, 1'b1, 8'hA5, 0, 0,  1'b1, 8'hA5, 1'b1};
    vecs[6] = '{14'd60, 1'b0, 1'b0, 8'h00, 9, 9,  1'b0, 8'h00, 1'b0};
    vecs[7] = '{14'd59, 1'b0, 1'b0, 8'h00, 9, 10, 1'b0, 8'h00, 1'b0};
    vecs[8] = '{14'd0,  1'b0, 1'b1, 8'h01, 0, 0,  1'b1, 8'h01, 1'b0};
    vecs[9] = '{14'd1,  1'b0, 1'b0, 8'h00, 2, 9,  1'b0, 8'h00, 1'b0};

    // Reset state.
    rst_n = 1'b0;
    step();
    check_idle_outputs("reset_outputs");
    rst_n = 1'b1;
    step();
    check_idle_outputs("post_reset_idle");

    // 1: single job, full-rate timing.
    clear_trace();
    push_job('{14'd16, 1'b0, 1'b0, 8'h00});
    drain("t1", 500);
    check("t1_nwr", 64'(n_wr_seen), PAD ? 64'd9 : 64'd3);
    if (pop_cyc.size() >= 1 && wr_cyc.size() >= 3 && ev_cyc.size() >= 1) begin
      check("t1_hdr_latency", 64'(wr_cyc[0] - pop_cyc[0]), 64'd1);
      check("t1_pl2_cycle", 64'(wr_cyc[2] - pop_cyc[0]), 64'd3);
      check("t1_ev_after_last", 64'(ev_cyc[0] - wr_cyc[wr_cyc.size()-1]), 64'd1);
    end else fail_now("t1_trace");

    // 2: concatenated jobs, back-to-back pop.
    clear_trace();
    push_job('{14'd8, 1'b1, 1'b0, 8'h00});
    push_job('{14'd13, 1'b0, 1'b0, 8'h00});
    drain("t2", 500);
    check("t2_nwr", 64'(n_wr_seen), PAD ? 64'd10 : 64'd5);
    check("t2_nev", 64'(n_ev_seen), 64'd2);
    if (pop_cyc.size() >= 2 && ev_cyc.size() >= 1)
      check("t2_b2b_pop", 64'(pop_cyc[1] - ev_cyc[0]), 64'd1);
    else fail_now("t2_trace");

    // 3: error job while idle.
    clear_trace();
    push_job('{14'd0, 1'b0, 1'b1, 8'h5A});
    drain("t3", 100);
    check("t3_nwr", 64'(n_wr_seen), 64'd0);
    check("t3_ev", {last_ev.err, last_ev.id, last_ev.abort}, {1'b1, 8'h5A, 1'b0});

    // 4: error inside an open frame aborts it; next job starts a new frame.
    clear_trace();
    push_job('{14'd8, 1'b1, 1'b0, 8'h00});
    push_job('{14'd0, 1'b0, 1'b1, 8'h33});
    push_job('{14'd8, 1'b0, 1'b0, 8'h00});
    drain("t4", 500);
    check("t4_nev", 64'(n_ev_seen), 64'd3);

    // 5: FIFO stall mid-payload with toggling payload availability.
    clear_trace();
    dav_mode = 2;
    push_job('{14'd24, 1'b0, 1'b0, 8'h00});
    step_until_writes(2);
    force_low = 3;
    drain("t5", 500);
    check("t5_nwr", 64'(n_wr_seen), PAD ? 64'd9 : 64'd4);
    dav_mode = 0;

    // 6: short frame, padded only with the feature enabled.
    clear_trace();
    push_job('{14'd10, 1'b0, 1'b0, 8'h00});
    drain("t6", 500);
    check("t6_nwr", 64'(n_wr_seen), PAD ? 64'd9 : 64'd3);

    // Vector table, random flow control.
    space_mode = 1;
    dav_mode = 1;
    foreach (vecs[k]) begin
      clear_trace();
      push_job('{vecs[k].len, vecs[k].concat, vecs[k].err, vecs[k].id});
      drain($sformatf("vec%0d", k), 1000);
      check($sformatf("vec%0d_nwr", k), 64'(n_wr_seen),
            64'(PAD ? vecs[k].nwr_pad : vecs[k].nwr_nopad));
      check($sformatf("vec%0d_nev", k), 64'(n_ev_seen), 64'd1);
      check($sformatf("vec%0d_ev", k), {last_ev.err, last_ev.id, last_ev.abort},
            {vecs[k].ev_err, vecs[k].ev_id, vecs[k].abort});
    end

    // Randomized job mix against the model.
    clear_trace();
    for (int i = 0; i < 150; i++) begin
      j.len    = (($urandom % 8) == 0) ? LEN_W'($urandom_range(41, 100)) : LEN_W'($urandom_range(0, 40));
      j.concat = (($urandom % 4) == 0);
      j.err    = (($urandom % 8) == 0);
      j.id     = 8'($urandom);
      push_job(j);
    end
    push_job('{14'd8, 1'b0, 1'b0, 8'h00});
    drain("rand", 20000);
    check("rand_nev", 64'(n_ev_seen), 64'd151);

    // 7: reset in the middle of a payload drops the frame silently.
    space_mode = 0;
    dav_mode = 0;
    clear_trace();
    push_job('{14'd24, 1'b0, 1'b0, 8'h00});
    step_until_writes(2);
    rst_n = 1'b0;
    step();
    check_idle_outputs("t7_reset_outputs");
    job_q.delete(); pl_q.delete(); exp_wr.delete(); exp_ev.delete();
    m_in_frame = 1'b0;
    step();
    check_idle_outputs("t7_reset_hold");
    rst_n = 1'b1;
    clear_trace();
    push_job('{14'd8, 1'b0, 1'b0, 8'h00});
    drain("t7", 500);
    nlast = n_wr_seen;
    check("t7_nwr", 64'(nlast), PAD ? 64'd9 : 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
